// File: rtl/e_mdu.sv
// e_mdu: multi-cycle MIPS multiply/divide unit with private HI/LO registers
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
                         OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] p_hi, p_lo;
  logic p_wr;
  logic is_md, is_div, div_zero;
  logic signed [31:0] a_s, b_s, dv_s, q_s, r_s;
  logic [31:0] dv_u, q_u, r_u;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, res;
  assign busy = state == RUN;
  assign md_active = start | busy;
  assign rd_data = op == OP_MFHI ? hi : op == OP_MFLO ? lo : '0;
  assign is_md = op >= OP_MULT && op <= OP_DIVU;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign div_zero = rt_data == '0;
  assign a_s = $signed(rs_data);
  assign b_s = $signed(rt_data);
  // a zero divisor is replaced by one so the dividers never produce X; the result is discarded anyway
  assign dv_s = div_zero ? 32'sd1 : b_s;
  assign dv_u = div_zero ? 32'd1 : rt_data;
  assign prod_s = 64'(a_s) * 64'(b_s);
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
  assign q_s = a_s / dv_s;
  assign r_s = a_s % dv_s;
  assign q_u = rs_data / dv_u;
  assign r_u = rs_data % dv_u;
  // select the {hi,lo} result of the requested operation
  always_comb begin
    res = op == OP_MULT  ? prod_s :
          op == OP_MULTU ? prod_u :
          op == OP_DIV   ? {r_s, q_s} : {r_u, q_u};
  end
  // idle/run control: latch result on accept, count down, write back on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        if (p_wr) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end
    end else if (start && is_md) begin
      state <= RUN;
      cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      p_hi  <= res[63:32];
      p_lo  <= res[31:0];
      p_wr  <= !(is_div && div_zero);
    end else if (op == OP_MTHI) begin
      hi <= rs_data;
    end else if (op == OP_MTLO) begin
      lo <= rs_data;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu
module tb_e_mdu;
  logic clk = 1'b0;
  logic reset, start;
  logic [3:0] op;
  logic [31:0] rs_data, rt_data;
  logic busy, md_active;
  logic [31:0] hi, lo, rd_data;
  int compared = 0;
  int mismatched = 0;
  int n;

  e_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy),
    .md_active(md_active), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    #1;
    chk("md_active_start", 32'(md_active), 32'd1);
    tick;
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      tick;
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0;
    tick; tick;
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy", 32'(busy), 32'd1);
    chk("mult_hi_hold", hi, 32'd0);
    wait_done(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_done(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd2);
    wait_done(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(4'd1, 32'd5, 32'd7);
    tick; tick;
    reset = 1'b1;
    tick;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    tick;
    reset = 1'b0;
    repeat (6) tick;
    chk("rst_late_busy", 32'(busy), 32'd0);
    chk("rst_late_lo", lo, 32'd0);

    op = 4'd7; rs_data = 32'h11; tick;
    op = 4'd8; rs_data = 32'h22; tick;
    op = 4'd0;
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    issue(4'd3, 32'd5, 32'd0);
    wait_done(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    issue(4'd3, 32'd100, 32'd7);
    start = 1'b1; op = 4'd1; rs_data = 32'd3; rt_data = 32'd3;
    #1;
    chk("ovl_md_active", 32'(md_active), 32'd1);
    tick;
    start = 1'b0; op = 4'd8; rs_data = 32'h55;
    tick;
    op = 4'd6;
    #1;
    chk("ovl_mflo", rd_data, 32'h22);
    chk("ovl_busy_active", 32'(md_active), 32'd1);
    chk("ovl_lo_kept", lo, 32'h22);
    op = 4'd0;
    wait_done(n);
    chk("ovl_cycles", 32'(n), 32'd8);
    chk("ovl_hi", hi, 32'd2);
    chk("ovl_lo", lo, 32'd14);
    tick;
    chk("ovl_no_mult", 32'(busy), 32'd0);
    chk("idle_md_active", 32'(md_active), 32'd0);
    op = 4'd5;
    #1;
    chk("mfhi", rd_data, 32'd2);
    op = 4'd9;
    #1;
    chk("rd_none", rd_data, 32'd0);

    issue(4'd1, 32'd6, 32'd7);
    wait_done(n);
    chk("b2b_mult_lo", lo, 32'd42);
    chk("b2b_mult_hi", hi, 32'd0);
    issue(4'd4, 32'd100, 32'd9);
    chk("b2b_accept", 32'(busy), 32'd1);
    chk("b2b_hold_lo", lo, 32'd42);
    wait_done(n);
    chk("b2b_cycles", 32'(n), 32'd10);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
